// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Brief    : Instruction fetch initiator. Issues registered imem reads,
//            absorbs the one-cycle imem read latency, buffers up to two
//            instructions for decode (valid/ready), and handles redirects
//            and misaligned-target faults.
// Options  : IFETCH_PERF_EN enables the perf_fetched / perf_stall counters
//            (ports always exist, tied to zero when disabled).
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_rd_en,
  output logic [31:0]      imem_pc,
  input  logic [WIDTH-1:0] imem_instr,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [31:0]      instr_pc,
  output logic             fetch_fault,
  output logic [31:0]      fault_pc,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_stall
);

  typedef enum logic [0:0] {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             rd_en_q, rd_en_d;
  logic [31:0]      imem_pc_q, imem_pc_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [1:0]       count_q, count_d;
  logic [31:0]      ent_pc_q [0:1];
  logic [31:0]      ent_pc_d [0:1];
  logic [WIDTH-1:0] ent_instr_q [0:1];
  logic [WIDTH-1:0] ent_instr_d [0:1];
  logic [31:0]      fault_pc_q, fault_pc_d;

  logic             resp_in;
  logic             head_valid;
  logic             fire;
  logic [1:0]       occ_next;
  logic             issue_ok;

  // Output mux: the FIFO head, or the returning response bypassed straight
  // to decode when the FIFO is empty (this gives one-per-cycle throughput).
  // A response arriving alongside a redirect is never presented.
  always_comb begin
    resp_in     = resp_valid_q & ~redirect_valid;
    head_valid  = (count_q != 2'd0);
    instr_valid = head_valid | resp_in;
    if (head_valid || !resp_valid_q) begin
      instr    = ent_instr_q[0];
      instr_pc = ent_pc_q[0];
    end else begin
      instr    = imem_instr;
      instr_pc = resp_pc_q;
    end
    fire = instr_valid & instr_ready;
  end

  // Next-state: FIFO update, issue decision, redirect and fault handling.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    rd_en_d        = 1'b0;
    imem_pc_d      = imem_pc_q;
    resp_valid_d   = rd_en_q;
    resp_pc_d      = imem_pc_q;
    count_d        = count_q;
    ent_pc_d[0]    = ent_pc_q[0];
    ent_pc_d[1]    = ent_pc_q[1];
    ent_instr_d[0] = ent_instr_q[0];
    ent_instr_d[1] = ent_instr_q[1];
    fault_pc_d     = fault_pc_q;

    // Shift-register FIFO: entry 0 is always the head.
    case (count_q)
      2'd0: begin
        if (resp_in && !fire) begin
          ent_pc_d[0] = resp_pc_q; ent_instr_d[0] = imem_instr; count_d = 2'd1;
        end
      end
      2'd1: begin
        if (fire) begin
          if (resp_in) begin
            ent_pc_d[0] = resp_pc_q; ent_instr_d[0] = imem_instr;
          end else begin
            count_d = 2'd0;
          end
        end else if (resp_in) begin
          ent_pc_d[1] = resp_pc_q; ent_instr_d[1] = imem_instr; count_d = 2'd2;
        end
      end
      default: begin
        if (fire) begin
          ent_pc_d[0] = ent_pc_q[1]; ent_instr_d[0] = ent_instr_q[1];
          if (resp_in) begin
            ent_pc_d[1] = resp_pc_q; ent_instr_d[1] = imem_instr;
          end else begin
            count_d = 2'd1;
          end
        end
      end
    endcase

    // Slots committed after this edge: buffered entries plus the request
    // currently at imem; a new request is allowed only if one slot remains.
    occ_next = count_q + {1'b0, resp_in} - {1'b0, fire};
    issue_ok = ({1'b0, occ_next} + {2'b00, rd_en_q}) < 3'd2;

    if (redirect_valid) begin
      count_d      = 2'd0;
      resp_valid_d = 1'b0;
      if (redirect_pc[1:0] == 2'b00) begin
        state_d    = RUN;
        rd_en_d    = 1'b1;
        imem_pc_d  = redirect_pc;
        fetch_pc_d = redirect_pc + 32'd4;
      end else begin
        state_d    = FAULT;
        fault_pc_d = redirect_pc;
      end
    end else if (state_q == RUN && issue_ok) begin
      rd_en_d    = 1'b1;
      imem_pc_d  = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= RUN;
      fetch_pc_q     <= RESET_PC;
      rd_en_q        <= 1'b0;
      imem_pc_q      <= RESET_PC;
      resp_valid_q   <= 1'b0;
      resp_pc_q      <= 32'h0;
      count_q        <= 2'd0;
      ent_pc_q[0]    <= 32'h0;
      ent_pc_q[1]    <= 32'h0;
      ent_instr_q[0] <= '0;
      ent_instr_q[1] <= '0;
      fault_pc_q     <= 32'h0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      rd_en_q        <= rd_en_d;
      imem_pc_q      <= imem_pc_d;
      resp_valid_q   <= resp_valid_d;
      resp_pc_q      <= resp_pc_d;
      count_q        <= count_d;
      ent_pc_q[0]    <= ent_pc_d[0];
      ent_pc_q[1]    <= ent_pc_d[1];
      ent_instr_q[0] <= ent_instr_d[0];
      ent_instr_q[1] <= ent_instr_d[1];
      fault_pc_q     <= fault_pc_d;
    end
  end

  assign imem_rd_en  = rd_en_q;
  assign imem_pc     = imem_pc_q;
  assign fetch_fault = (state_q == FAULT);
  assign fault_pc    = fault_pc_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Count decode pops and decode-stalled cycles; both wrap naturally.
  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'd0, fire};
    perf_stall_d   = perf_stall_q + {31'd0, instr_valid & ~instr_ready};
  end

  // Counter registers, zeroed on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched_q <= 32'h0;
      perf_stall_q   <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`else
  assign perf_fetched = 32'h0;
  assign perf_stall   = 32'h0;
`endif

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch initiator that drives the imem read port (rd_en/pc) and collects returned instructions. It absorbs imem's one-cycle registered read latency, buffers up to two instructions for the decode stage behind a valid/ready handshake, and handles branch/jump redirects and misaligned-target faults. It sits between the PC-redirect logic (execute stage) and decode.

Parameters:
WIDTH, 32, instruction width in bits (matches imem WIDTH)
RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
imem_rd_en  out  1  read enable to imem
imem_pc  out  32  byte address to imem
imem_instr  in  WIDTH  imem read data, valid the cycle after the request
redirect_valid  in  1  one-cycle pulse: discard current stream and restart at redirect_pc
redirect_pc  in  32  new fetch target
instr_valid  out  1  instr/instr_pc hold a valid instruction for decode
instr_ready  in  1  decode accepts when instr_valid & instr_ready
instr  out  WIDTH  fetched instruction
instr_pc  out  32  address of instr
fetch_fault  out  1  misaligned redirect target; held until next aligned redirect
fault_pc  out  32  offending redirect_pc

Behaviour:
- Reset (rst=0 sampled at edge): fetch_pc=RESET_PC, buffer empty, no request in flight, state RUN; outputs imem_rd_en=0, imem_pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0, fault_pc=0. Reset mid-request discards the in-flight response.
- Request timing: imem_rd_en=1 with imem_pc=A in cycle N -> imem_instr for A is consumed in cycle N+1. imem_pc/imem_rd_en are driven from registers (no combinational path from instr_ready or redirect_valid).
- Output buffer: 2-entry FIFO of {pc, instr}; head drives instr/instr_pc/instr_valid. Pop on instr_valid & instr_ready.
- Issue rule: in RUN, issue when (occupancy + inflight) < 2, counted after this cycle's pop; after issue fetch_pc += 4. Full throughput = one instruction per cycle with instr_ready held high; first instr_valid 2 cycles after rst deasserts.
- Backpressure: instr_ready=0 never loses or duplicates an instruction; at most 2 buffered + 0 in flight, or 1 + 1.
- Wrap-around: fetch_pc 32'hFFFF_FFFC + 4 wraps to 0, no fault.
- States: RUN (issuing), FAULT (no issue, imem_rd_en=0).
- Redirect (redirect_valid=1 in cycle N): buffer flushed and in-flight response dropped at edge N (instr_valid=0 in N+1); the pop in cycle N, if any, still counts. If redirect_pc[1:0]==0: fetch_pc=redirect_pc, first request issued in N+1, state RUN. Else: state FAULT, fetch_fault=1, fault_pc=redirect_pc from N+1.
- FAULT exits only on aligned redirect (fetch_fault cleared next cycle). A misaligned redirect while already in FAULT updates fault_pc.
- Redirect in the same cycle as a returning response: redirect wins, response discarded.
- rst=0 in the same cycle as redirect_valid: reset wins.

Optional Feature:
IFETCH_PERF_EN: defined -> adds 32-bit counters perf_fetched (pops to decode) and perf_stall (cycles with instr_valid=1 & instr_ready=0), exposed as outputs perf_fetched/perf_stall, zeroed on reset, wrap at 2^32. Not defined -> both ports still present, tied to 0, no counter logic.

Test Plan:
- Reset release, instr_ready=1, imem preloaded with words W0..W7 -> instr W0..W7 on consecutive cycles with instr_pc 0,4,...,28; first instr_valid 2 cycles after rst=1.
- instr_ready=0 for 5 cycles after the first instruction -> instr_valid stays 1, imem_rd_en drops once 2 are held, resume yields W1,W2,W3 in order, no gaps or duplicates.
- redirect_valid pulse with redirect_pc=0x40 while a response is in flight -> stale data never appears; next accepted instr_pc=0x40, then 0x44.
- redirect_pc=0x43 -> fetch_fault=1, fault_pc=0x43, imem_rd_en=0, instr_valid=0; later redirect to 0x10 -> fault cleared, instr_pc=0x10.
- rst=0 asserted mid-stream with 2 buffered -> next cycle instr_valid=0, imem_pc=RESET_PC; fetch restarts from RESET_PC.
- With IFETCH_PERF_EN, 8 accepted and 5 stalled cycles -> perf_fetched=8, perf_stall=5; without it both read 0.
